// File: rtl/ve370_pipe_pkg.sv
// Shared constants for the ve370 5-stage pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ve370_pipe_pkg;

  // Default datapath and field widths for the MIPS core
  localparam int WIDTH_DEF  = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int REG_W_DEF  = 5;

  // Operand-mux select encoding; 2'b11 is never generated
  localparam logic [1:0] FWD_REG = 2'b00;  // register-file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB writeback value
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

  // $zero is hardwired, so it is never a forwarding or hazard source
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_forward_stage_forward_sel.sv
// Forwarding select for one EX operand: picks RF, MEM/WB or EX/MEM value.
// Latency: purely combinational.
// Backpressure: none; always produces a select.
module forward_sel
  import ve370_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             src_valid,
  input  logic [REG_W-1:0] src_reg,
  input  logic             exmem_reg_write,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             memwb_reg_write,
  input  logic [REG_W-1:0] memwb_rd,
  output logic [1:0]       sel
);

  logic exmem_hit;
  logic memwb_hit;

  // A producer matches only if it writes a nonzero register equal to the source
  assign exmem_hit = exmem_reg_write && (exmem_rd != REG_W'(REG_ZERO)) && (exmem_rd == src_reg);
  assign memwb_hit = memwb_reg_write && (memwb_rd != REG_W'(REG_ZERO)) && (memwb_rd == src_reg);

  // EX/MEM holds the newer value, so it beats MEM/WB; bubbles never forward
  always_comb begin
    sel = FWD_REG;
    if (src_valid) begin
      if (exmem_hit) begin
        sel = FWD_MEM;
      end else if (memwb_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand forwarding selects and load-use stall.
// Latency: 1 cycle from id_* to ex_*; selects and stall are combinational.
// Backpressure: raises stall for one cycle on load-use; PC and IF/ID hold.
module id_ex_forward_stage
  import ve370_pipe_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [WIDTH-1:0]  id_rs_data,
  input  logic [WIDTH-1:0]  id_rt_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [WIDTH-1:0]  ex_rs_data,
  output logic [WIDTH-1:0]  ex_rt_data,
  output logic [WIDTH-1:0]  ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall
);

  logic hazard;
  logic bubble;

  // A load in EX whose destination is read by the instruction in ID
  assign hazard = ex_valid && ex_mem_read && id_valid
                  && (ex_rd != REG_W'(REG_ZERO))
                  && ((ex_rd == id_rs) || (ex_rd == id_rt));

  // A squashed ID instruction needs no stall; it is discarded anyway
  assign stall  = hazard && !flush;

  // Anything not a live, unstalled instruction enters EX as a bubble
  assign bubble = flush || stall || !id_valid;

  // Capture ID; bubbles clear only the fields that can cause effects downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
    end else begin
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_ctrl      <= '0;
      end else begin
        ex_valid     <= 1'b1;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        ex_ctrl      <= id_ctrl;
      end
    end
  end

  forward_sel #(.REG_W(REG_W)) u_fwd_a (
    .src_valid       (ex_valid),
    .src_reg         (ex_rs),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (fwd_a_sel)
  );

  forward_sel #(.REG_W(REG_W)) u_fwd_b (
    .src_valid       (ex_valid),
    .src_reg         (ex_rt),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (fwd_b_sel)
  );

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Bench for id_ex_forward_stage: scoreboard of expected EX contents plus hazard/forward model.
// Latency: expects ex_* one edge after ID drive; selects and stall same cycle.
// Backpressure: models the one-cycle load-use bubble.
module tb_id_ex_forward_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read;
  logic [7:0]  id_ctrl;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic        ex_reg_write, ex_mem_read;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic        reg_write, mem_read;
    logic [7:0]  ctrl;
  } ex_t;

  ex_t m;
  ex_t q[$];
  int  checks = 0;
  int  errors = 0;

  id_ex_forward_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic rw, input logic mr,
                       input logic [7:0] ctl, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_reg_write = rw; id_mem_read = mr; id_ctrl = ctl; flush = fl;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic ww, input logic [4:0] wrd);
    exmem_reg_write = ew; exmem_rd = erd; memwb_reg_write = ww; memwb_rd = wrd;
  endtask

  function automatic logic exp_stall();
    logic hz;
    hz = m.valid && m.mem_read && id_valid && (m.rd != 5'd0) && ((m.rd == id_rs) || (m.rd == id_rt));
    return hz && !flush;
  endfunction

  function automatic logic [1:0] exp_sel(input logic [4:0] src);
    if (!m.valid) return 2'b00;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == src) return 2'b10;
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Combinational outputs against the model's current EX contents
  task automatic comb_check(input string tag);
    #1;
    check_val({tag, "_stall"}, 32'(stall), 32'(exp_stall()));
    check_val({tag, "_fwda"}, 32'(fwd_a_sel), 32'(exp_sel(m.rs)));
    check_val({tag, "_fwdb"}, 32'(fwd_b_sel), 32'(exp_sel(m.rt)));
  endtask

  // Push expected EX state, take one edge, pop and compare
  task automatic cycle(input string tag);
    ex_t n;
    ex_t e;
    logic bub;
    comb_check(tag);
    bub = flush || exp_stall() || !id_valid;
    n.valid = !bub;
    n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
    n.rs_data = id_rs_data; n.rt_data = id_rt_data; n.imm = id_imm;
    n.reg_write = !bub && id_reg_write;
    n.mem_read  = !bub && id_mem_read;
    n.ctrl      = bub ? 8'h00 : id_ctrl;
    q.push_back(n);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_val({tag, "_valid"}, 32'(ex_valid), 32'(e.valid));
    check_val({tag, "_rw"}, 32'(ex_reg_write), 32'(e.reg_write));
    check_val({tag, "_mr"}, 32'(ex_mem_read), 32'(e.mem_read));
    check_val({tag, "_ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
    if (e.valid) begin
      check_val({tag, "_rs"}, 32'(ex_rs), 32'(e.rs));
      check_val({tag, "_rt"}, 32'(ex_rt), 32'(e.rt));
      check_val({tag, "_rd"}, 32'(ex_rd), 32'(e.rd));
      check_val({tag, "_rsd"}, ex_rs_data, e.rs_data);
      check_val({tag, "_rtd"}, ex_rt_data, e.rt_data);
      check_val({tag, "_imm"}, ex_imm, e.imm);
    end
    m = e;
    @(negedge clk);
  endtask

  initial begin
    m = '0;
    // Reset held from time zero with live-looking ID inputs
    rst_n = 1'b0;
    set_fwd(1'b1, 5'd3, 1'b1, 5'd4);
    drive(1'b1, 5'd3, 5'd4, 5'd5, 32'hdead, 32'hbeef, 32'h1, 1'b1, 1'b1, 8'hff, 1'b0);
    #3;
    check_val("rst0_valid", 32'(ex_valid), 32'd0);
    check_val("rst0_stall", 32'(stall), 32'd0);
    check_val("rst0_fwda", 32'(fwd_a_sel), 32'd0);
    check_val("rst0_ctrl", 32'(ex_ctrl), 32'd0);
    check_val("rst0_rsd", ex_rs_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain instruction flows through with no forwarding
    set_fwd(1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 1'b1, 1'b0, 8'ha5, 1'b0);
    cycle("basic");
    check_val("basic_rsd_k", ex_rs_data, 32'h11);
    check_val("basic_rd_k", 32'(ex_rd), 32'd5);
    check_val("basic_valid_k", 32'(ex_valid), 32'd1);
    check_val("basic_fwda_k", 32'(fwd_a_sel), 32'd0);
    check_val("basic_fwdb_k", 32'(fwd_b_sel), 32'd0);

    // Dependent instruction reading $5 enters EX
    drive(1'b1, 5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 32'h0, 1'b1, 1'b0, 8'h3c, 1'b0);
    cycle("dep");
    set_fwd(1'b1, 5'd5, 1'b1, 5'd5);
    comb_check("fwd_both");
    check_val("fwd_both_k", 32'(fwd_a_sel), 32'd2);
    set_fwd(1'b0, 5'd5, 1'b1, 5'd5);
    comb_check("fwd_wb");
    check_val("fwd_wb_k", 32'(fwd_a_sel), 32'd1);
    set_fwd(1'b1, 5'd6, 1'b1, 5'd5);
    comb_check("fwd_mix");
    check_val("fwd_mix_b_k", 32'(fwd_b_sel), 32'd2);

    // Register zero is never forwarded
    set_fwd(1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 8'h01, 1'b0);
    cycle("zero");
    set_fwd(1'b1, 5'd0, 1'b1, 5'd0);
    comb_check("zero_fwd");
    check_val("zero_fwda_k", 32'(fwd_a_sel), 32'd0);

    // lw $8 then a reader of $8: one stall, one bubble, then MEM/WB forward
    set_fwd(1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'h8, 1'b1, 1'b1, 8'h42, 1'b0);
    cycle("lw");
    drive(1'b1, 5'd2, 5'd8, 5'd10, 32'h200, 32'h300, 32'h0, 1'b1, 1'b0, 8'h24, 1'b0);
    #1;
    check_val("lu_stall_k", 32'(stall), 32'd1);
    cycle("lu_stall");
    check_val("lu_bubble_valid_k", 32'(ex_valid), 32'd0);
    check_val("lu_bubble_rw_k", 32'(ex_reg_write), 32'd0);
    set_fwd(1'b1, 5'd8, 1'b0, 5'd0);
    cycle("lu_resume");
    check_val("lu_valid_k", 32'(ex_valid), 32'd1);
    set_fwd(1'b0, 5'd0, 1'b1, 5'd8);
    comb_check("lu_fwd");
    check_val("lu_fwdb_k", 32'(fwd_b_sel), 32'd1);

    // Load-use coinciding with flush: no stall, bubble loaded
    set_fwd(1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h11, 1'b0);
    cycle("fl_lw");
    drive(1'b1, 5'd8, 5'd3, 5'd11, 32'h7, 32'h9, 32'h0, 1'b1, 1'b0, 8'h77, 1'b1);
    #1;
    check_val("fl_stall_k", 32'(stall), 32'd0);
    cycle("fl_dep");
    check_val("fl_valid_k", 32'(ex_valid), 32'd0);

    // Mixed random traffic checked against the model
    for (int i = 0; i < 60; i++) begin
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            8'($urandom), 1'($urandom_range(0, 4) == 0));
      cycle("rnd");
    end

    // Reset asserted while a stall is pending drops stall without a clock edge
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0);
    set_fwd(1'b0, 5'd0, 1'b0, 5'd0);
    cycle("idle");
    drive(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 8'h99, 1'b0);
    cycle("rst_lw");
    drive(1'b1, 5'd8, 5'd4, 5'd12, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 8'h12, 1'b0);
    set_fwd(1'b1, 5'd8, 1'b1, 5'd8);
    comb_check("rst_pre");
    check_val("rst_pre_stall_k", 32'(stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rstm_stall", 32'(stall), 32'd0);
    check_val("rstm_valid", 32'(ex_valid), 32'd0);
    check_val("rstm_mr", 32'(ex_mem_read), 32'd0);
    check_val("rstm_ctrl", 32'(ex_ctrl), 32'd0);
    check_val("rstm_rd", 32'(ex_rd), 32'd0);
    check_val("rstm_fwda", 32'(fwd_a_sel), 32'd0);
    m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, directly upstream of the two EX-stage 3:1 operand muxes.
- Latches decoded operands and control from ID.
- Generates the 2-bit forwarding selects that drive the operand muxes.
- Detects load-use hazards; inserts bubbles on stall or branch flush.

Parameters:
- WIDTH, 32, datapath width of operands and immediate
- CTRL_W, 8, width of opaque pass-through EX/MEM/WB control bundle
- REG_W, 5, register-number width

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  branch-taken squash of the instruction in ID
- id_valid  input  1  ID holds a real instruction
- id_rs  input  REG_W  source register 1 number
- id_rt  input  REG_W  source register 2 number
- id_rd  input  REG_W  destination register, already resolved by ID (rd or rt)
- id_rs_data  input  WIDTH  register-file read 1
- id_rt_data  input  WIDTH  register-file read 2
- id_imm  input  WIDTH  sign-extended immediate
- id_reg_write  input  1  instruction writes a register
- id_mem_read  input  1  instruction is a load
- id_ctrl  input  CTRL_W  remaining control, passed through untouched
- exmem_reg_write  input  1  EX/MEM instruction writes a register
- exmem_rd  input  REG_W  EX/MEM destination register
- memwb_reg_write  input  1  MEM/WB instruction writes a register
- memwb_rd  input  REG_W  MEM/WB destination register
- ex_valid  output  1  EX holds a real instruction
- ex_rs  output  REG_W  latched rs
- ex_rt  output  REG_W  latched rt
- ex_rd  output  REG_W  latched rd
- ex_rs_data  output  WIDTH  latched rs data
- ex_rt_data  output  WIDTH  latched rt data
- ex_imm  output  WIDTH  latched immediate
- ex_reg_write  output  1  latched, gated by valid
- ex_mem_read  output  1  latched, gated by valid
- ex_ctrl  output  CTRL_W  latched control
- fwd_a_sel  output  2  operand-A mux select
- fwd_b_sel  output  2  operand-B mux select
- stall  output  1  load-use stall request; PC and IF/ID hold while high

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs clear to 0.
  - ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_ctrl=0, all data and register numbers 0.
  - fwd_a_sel and fwd_b_sel therefore read 2'b00; stall reads 0.
- Latency: 1 cycle. ID values appear on the ex_* outputs after the next rising edge.
- Bubble condition: flush, or stall, or !id_valid.
  - On a bubble edge, load ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_ctrl=0.
  - Data and register fields may load freely but must not cause forwarding or writes.
- Normal edge: load all id_* fields, with ex_valid=1.
- Load-use detect (combinational):
  - hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt).
  - stall = hazard & !flush. Flush wins because the ID instruction is being squashed anyway.
- A stall lasts exactly 1 cycle. The bubble clears ex_mem_read, so hazard drops on the next cycle.
- Forwarding selects (combinational from ex_rs/ex_rt and the EX/MEM and MEM/WB inputs). Encoding matches the operand mux:
  - 2'b00: register-file value
  - 2'b01: MEM/WB writeback value
  - 2'b10: EX/MEM ALU result
  - 2'b11: never driven (the mux outputs 0 for this code)
- fwd_a_sel rule:
  - 2'b10 if exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rs
  - else 2'b01 if memwb_reg_write & memwb_rd != 0 & memwb_rd == ex_rs
  - else 2'b00
- fwd_b_sel: same rule using ex_rt.
- EX/MEM takes priority over MEM/WB when both match, because it holds the newer value.
- Register 0 is never forwarded.
- When ex_valid=0, both selects are 2'b00.
- Reset mid-stall: stall drops immediately, because ex_valid is cleared asynchronously.

Decomposition:
- Package ve370_pipe_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_ZERO=5'd0
  - default CTRL_W and REG_W
- One natural sub-module: forward_sel, purely combinational. It takes a source register plus the EX/MEM and MEM/WB write info and returns a 2-bit select. It is instantiated twice, once for rs and once for rt.

Test Plan:
- Reset with rst_n=0 mid-cycle, id inputs nonzero → all outputs 0 immediately, before any clock edge; stall=0.
- id_valid=1, rs=3, rt=4, rd=5, rs_data=0x11 → after 1 edge, ex_rs_data=0x11, ex_rd=5, ex_valid=1, fwd selects 00.
- Issue add $5,... then the next instruction reads rs=5, with EX/MEM rd=5 and MEM/WB rd=5, both writing → fwd_a_sel=2'b10; with exmem_reg_write=0 → 2'b01.
- rs=0, exmem_rd=0, exmem_reg_write=1 → fwd_a_sel=2'b00.
- lw into $8 in EX (ex_mem_read=1), ID reads rt=8 → stall=1 for exactly 1 cycle. The next edge loads a bubble (ex_valid=0, ex_reg_write=0), then stall=0. On the following edge the dependent instruction enters EX with fwd_b_sel=2'b01 once the load reaches MEM/WB.
- Load-use hazard with flush=1 simultaneously → stall=0, and the next edge loads a bubble.
